// File: rtl/e_stage_md.sv
// Execute stage with E/M pipeline register and an iterative multiply/divide unit.
// Define MULT_DIV_EN to compile in the multiply/divide unit and HI/LO registers.
module e_stage_md #(
  parameter int          MULT_CYCLES = 5,
  parameter int          DIV_CYCLES  = 10,
  parameter logic [31:0] RESET_PC    = 32'h00003000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] E_pc,
  input  logic [31:0] E_rs_val,
  input  logic [31:0] E_rt_val,
  input  logic [31:0] E_imm32,
  input  logic        E_alusrc,
  input  logic [3:0]  E_aluop,
  input  logic [2:0]  E_mdop,
  input  logic [1:0]  E_wbsel,
  input  logic [4:0]  E_a3,
  input  logic        E_grf_en,
  input  logic        E_dm_en,
  input  logic        E_flush,
  output logic        md_busy,
  output logic [31:0] M_aluo,
  output logic [31:0] M_vinn,
  output logic [31:0] M_vin,
  output logic [4:0]  M_a3,
  output logic        M_grf_en,
  output logic        M_dm_en,
  output logic [31:0] M_pc
);

  logic [31:0] alu_b;
  logic [31:0] alu_res;
  logic [31:0] hi;
  logic [31:0] lo;
  logic [31:0] wb_val;

  assign alu_b = E_alusrc ? E_imm32 : E_rt_val;

  always_comb begin
    alu_res = 32'd0;
    case (E_aluop)
      4'd0: alu_res = E_rs_val + alu_b;
      4'd1: alu_res = E_rs_val - alu_b;
      4'd2: alu_res = E_rs_val & alu_b;
      4'd3: alu_res = E_rs_val | alu_b;
      4'd4: alu_res = E_rs_val ^ alu_b;
      4'd5: alu_res = ~(E_rs_val | alu_b);
      4'd6: alu_res = {alu_b[15:0], 16'd0};
      4'd7: alu_res = {31'd0, $signed(E_rs_val) < $signed(alu_b)};
      4'd8: alu_res = {31'd0, E_rs_val < alu_b};
      default: alu_res = 32'd0;
    endcase
  end

`ifdef MULT_DIV_EN
  typedef enum logic {IDLE, BUSY} md_state_t;

  md_state_t   state;
  logic [31:0] cnt;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic [2:0]  md_op;
  logic [63:0] prod_s;
  logic [63:0] prod_u;
  logic [31:0] quo_s;
  logic [31:0] rem_s;
  logic [31:0] quo_u;
  logic [31:0] rem_u;

  // Results are computed from the latched operands and only committed at completion.
  assign prod_s = {{32{op_a[31]}}, op_a} * {{32{op_b[31]}}, op_b};
  assign prod_u = {32'd0, op_a} * {32'd0, op_b};
  assign quo_s  = $signed(op_a) / $signed(op_b);
  assign rem_s  = $signed(op_a) % $signed(op_b);
  assign quo_u  = op_a / op_b;
  assign rem_u  = op_a % op_b;

  assign md_busy = (state == BUSY);

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= 32'd0;
      op_a  <= 32'd0;
      op_b  <= 32'd0;
      md_op <= 3'd0;
      hi    <= 32'd0;
      lo    <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          case (E_mdop)
            3'd1, 3'd2, 3'd3, 3'd4: begin
              op_a  <= E_rs_val;
              op_b  <= E_rt_val;
              md_op <= E_mdop;
              cnt   <= (E_mdop <= 3'd2) ? 32'(MULT_CYCLES) : 32'(DIV_CYCLES);
              state <= BUSY;
            end
            3'd5: hi <= E_rs_val;
            3'd6: lo <= E_rs_val;
            default: ;
          endcase
        end
        BUSY: begin
          // The hazard unit must hold any HI/LO instruction while the unit runs.
          assert (!(E_mdop inside {[3'd1:3'd6]}));
          if (cnt == 32'd1) begin
            state <= IDLE;
            cnt   <= 32'd0;
            case (md_op)
              3'd1: {hi, lo} <= prod_s;
              3'd2: {hi, lo} <= prod_u;
              3'd3: if (op_b != 32'd0) begin
                lo <= quo_s;
                hi <= rem_s;
              end
              3'd4: if (op_b != 32'd0) begin
                lo <= quo_u;
                hi <= rem_u;
              end
              default: ;
            endcase
          end else begin
            cnt <= cnt - 32'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
`else
  logic unused_md;

  assign unused_md = ^{E_mdop, MULT_CYCLES[0], DIV_CYCLES[0]};
  assign md_busy   = 1'b0;
  assign hi        = 32'd0;
  assign lo        = 32'd0;
`endif

  always_comb begin
    wb_val = 32'd0;
    case (E_wbsel)
      2'd0: wb_val = alu_res;
      2'd1: wb_val = hi;
      2'd2: wb_val = lo;
      2'd3: wb_val = E_pc + 32'd8;
      default: wb_val = 32'd0;
    endcase
  end

  // A flushed slot keeps its PC so exception/debug logic downstream still sees it.
  always_ff @(posedge clk) begin
    if (reset) begin
      M_aluo   <= 32'd0;
      M_vinn   <= 32'd0;
      M_vin    <= 32'd0;
      M_a3     <= 5'd0;
      M_grf_en <= 1'b0;
      M_dm_en  <= 1'b0;
      M_pc     <= RESET_PC;
    end else if (E_flush) begin
      M_aluo   <= 32'd0;
      M_vinn   <= 32'd0;
      M_vin    <= 32'd0;
      M_a3     <= 5'd0;
      M_grf_en <= 1'b0;
      M_dm_en  <= 1'b0;
      M_pc     <= E_pc;
    end else begin
      M_aluo   <= alu_res;
      M_vinn   <= E_rt_val;
      M_vin    <= wb_val;
      M_a3     <= E_a3;
      M_grf_en <= E_grf_en;
      M_dm_en  <= E_dm_en;
      M_pc     <= E_pc;
    end
  end

endmodule

// File: tb/tb_e_stage_md.sv
// Directed self-checking bench for e_stage_md; multiply/divide checks follow MULT_DIV_EN.
module tb_e_stage_md;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] E_pc = 32'h00003000;
  logic [31:0] E_rs_val = 32'd0;
  logic [31:0] E_rt_val = 32'd0;
  logic [31:0] E_imm32 = 32'd0;
  logic        E_alusrc = 1'b0;
  logic [3:0]  E_aluop = 4'd0;
  logic [2:0]  E_mdop = 3'd0;
  logic [1:0]  E_wbsel = 2'd0;
  logic [4:0]  E_a3 = 5'd0;
  logic        E_grf_en = 1'b0;
  logic        E_dm_en = 1'b0;
  logic        E_flush = 1'b0;
  logic        md_busy;
  logic [31:0] M_aluo;
  logic [31:0] M_vinn;
  logic [31:0] M_vin;
  logic [4:0]  M_a3;
  logic        M_grf_en;
  logic        M_dm_en;
  logic [31:0] M_pc;

  int checks = 0;
  int errors = 0;
  int busy_cnt;

  e_stage_md dut (
    .clk(clk), .reset(reset), .E_pc(E_pc), .E_rs_val(E_rs_val), .E_rt_val(E_rt_val),
    .E_imm32(E_imm32), .E_alusrc(E_alusrc), .E_aluop(E_aluop), .E_mdop(E_mdop),
    .E_wbsel(E_wbsel), .E_a3(E_a3), .E_grf_en(E_grf_en), .E_dm_en(E_dm_en),
    .E_flush(E_flush), .md_busy(md_busy), .M_aluo(M_aluo), .M_vinn(M_vinn),
    .M_vin(M_vin), .M_a3(M_a3), .M_grf_en(M_grf_en), .M_dm_en(M_dm_en), .M_pc(M_pc)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Drives one E-stage instruction, clocks it into E/M and returns #1 after the edge.
  task automatic applyStimulus(input logic [3:0] aluop, input logic [31:0] rs, input logic [31:0] rt,
                               input logic [31:0] imm, input logic alusrc, input logic [2:0] mdop,
                               input logic [1:0] wbsel);
    E_aluop  = aluop;
    E_rs_val = rs;
    E_rt_val = rt;
    E_imm32  = imm;
    E_alusrc = alusrc;
    E_mdop   = mdop;
    E_wbsel  = wbsel;
    @(posedge clk);
    #1;
    E_mdop = 3'd0;
  endtask

  task automatic waitIdle(output int cycles);
    cycles = 0;
    while (md_busy && cycles < 50) begin
      @(posedge clk);
      #1;
      cycles++;
    end
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_pc", M_pc, 32'h00003000);
    checkOutput("rst_aluo", M_aluo, 32'd0);
    checkOutput("rst_vin", M_vin, 32'd0);
    checkOutput("rst_vinn", M_vinn, 32'd0);
    checkOutput("rst_ctl", {25'd0, M_a3, M_grf_en, M_dm_en}, 32'd0);
    checkOutput("rst_busy", {31'd0, md_busy}, 32'd0);
    reset = 1'b0;

    E_pc = 32'h00003004; E_a3 = 5'd9; E_grf_en = 1'b1; E_dm_en = 1'b1;
    applyStimulus(4'd0, 32'hFFFFFFFF, 32'd1, 32'd0, 1'b0, 3'd0, 2'd0);
    checkOutput("addu", M_aluo, 32'd0);
    checkOutput("addu_vinn", M_vinn, 32'd1);
    checkOutput("pass_ctl", {25'd0, M_a3, M_grf_en, M_dm_en}, {25'd0, 5'd9, 1'b1, 1'b1});
    checkOutput("pass_pc", M_pc, 32'h00003004);
    E_dm_en = 1'b0;
    applyStimulus(4'd7, 32'hFFFFFFFF, 32'd1, 32'd0, 1'b0, 3'd0, 2'd0);
    checkOutput("slt", M_aluo, 32'd1);
    checkOutput("slt_vin", M_vin, 32'd1);
    applyStimulus(4'd8, 32'hFFFFFFFF, 32'd1, 32'd0, 1'b0, 3'd0, 2'd0);
    checkOutput("sltu", M_aluo, 32'd0);
    applyStimulus(4'd1, 32'hFFFFFFFF, 32'd1, 32'd0, 1'b0, 3'd0, 2'd0);
    checkOutput("subu", M_aluo, 32'hFFFFFFFE);
    applyStimulus(4'd2, 32'hF0F0F0F0, 32'h0FF00FF0, 32'd0, 1'b0, 3'd0, 2'd0);
    checkOutput("and", M_aluo, 32'h00F000F0);
    applyStimulus(4'd3, 32'hF0F0F0F0, 32'h0FF00FF0, 32'd0, 1'b0, 3'd0, 2'd0);
    checkOutput("or", M_aluo, 32'hFFF0FFF0);
    applyStimulus(4'd4, 32'hF0F0F0F0, 32'h0FF00FF0, 32'd0, 1'b0, 3'd0, 2'd0);
    checkOutput("xor", M_aluo, 32'hFF00FF00);
    applyStimulus(4'd5, 32'hF0F0F0F0, 32'h0FF00FF0, 32'd0, 1'b0, 3'd0, 2'd0);
    checkOutput("nor", M_aluo, 32'h000F000F);
    applyStimulus(4'd6, 32'h12345678, 32'd0, 32'h0000ABCD, 1'b1, 3'd0, 2'd0);
    checkOutput("lui_imm", M_aluo, 32'hABCD0000);
    applyStimulus(4'd0, 32'd100, 32'd5, 32'hFFFFFFFF, 1'b1, 3'd0, 2'd0);
    checkOutput("addiu_imm", M_aluo, 32'd99);
    applyStimulus(4'd9, 32'd100, 32'd5, 32'd0, 1'b0, 3'd0, 2'd0);
    checkOutput("bad_op", M_aluo, 32'd0);

    E_pc = 32'h00003010;
    applyStimulus(4'd0, 32'd1, 32'd2, 32'd0, 1'b0, 3'd0, 2'd3);
    checkOutput("link_vin", M_vin, 32'h00003018);
    checkOutput("link_aluo", M_aluo, 32'd3);

    E_pc = 32'h00003020; E_flush = 1'b1; E_grf_en = 1'b1; E_dm_en = 1'b1; E_a3 = 5'd31;
    applyStimulus(4'd0, 32'd1, 32'd2, 32'd0, 1'b0, 3'd0, 2'd0);
    checkOutput("flush_ctl", {25'd0, M_a3, M_grf_en, M_dm_en}, 32'd0);
    checkOutput("flush_data", M_aluo | M_vin | M_vinn, 32'd0);
    checkOutput("flush_pc", M_pc, 32'h00003020);
    E_flush = 1'b0; E_dm_en = 1'b0;

`ifdef MULT_DIV_EN
    applyStimulus(4'd0, 32'hFFFFFFFE, 32'd3, 32'd0, 1'b0, 3'd1, 2'd0);
    checkOutput("mult_busy", {31'd0, md_busy}, 32'd1);
    waitIdle(busy_cnt);
    checkOutput("mult_cycles", busy_cnt, 32'd5);
    applyStimulus(4'd0, 32'd0, 32'd0, 32'd0, 1'b0, 3'd0, 2'd2);
    checkOutput("mult_lo", M_vin, 32'hFFFFFFFA);
    applyStimulus(4'd0, 32'd0, 32'd0, 32'd0, 1'b0, 3'd0, 2'd1);
    checkOutput("mult_hi", M_vin, 32'hFFFFFFFF);

    applyStimulus(4'd0, 32'd7, 32'd0, 32'd0, 1'b0, 3'd4, 2'd0);
    waitIdle(busy_cnt);
    checkOutput("divu0_cycles", busy_cnt, 32'd10);
    applyStimulus(4'd0, 32'd0, 32'd0, 32'd0, 1'b0, 3'd0, 2'd2);
    checkOutput("divu0_lo", M_vin, 32'hFFFFFFFA);
    applyStimulus(4'd0, 32'd0, 32'd0, 32'd0, 1'b0, 3'd0, 2'd1);
    checkOutput("divu0_hi", M_vin, 32'hFFFFFFFF);

    applyStimulus(4'd0, 32'hFFFFFFF9, 32'd2, 32'd0, 1'b0, 3'd3, 2'd0);
    waitIdle(busy_cnt);
    checkOutput("div_cycles", busy_cnt, 32'd10);
    applyStimulus(4'd0, 32'd0, 32'd0, 32'd0, 1'b0, 3'd0, 2'd2);
    checkOutput("div_lo", M_vin, 32'hFFFFFFFD);
    applyStimulus(4'd0, 32'd0, 32'd0, 32'd0, 1'b0, 3'd0, 2'd1);
    checkOutput("div_hi", M_vin, 32'hFFFFFFFF);

    applyStimulus(4'd0, 32'd100, 32'd7, 32'd0, 1'b0, 3'd4, 2'd0);
    waitIdle(busy_cnt);
    applyStimulus(4'd0, 32'd0, 32'd0, 32'd0, 1'b0, 3'd0, 2'd2);
    checkOutput("divu_lo", M_vin, 32'd14);
    applyStimulus(4'd0, 32'd0, 32'd0, 32'd0, 1'b0, 3'd0, 2'd1);
    checkOutput("divu_hi", M_vin, 32'd2);

    applyStimulus(4'd0, 32'h80000000, 32'h80000000, 32'd0, 1'b0, 3'd2, 2'd0);
    waitIdle(busy_cnt);
    applyStimulus(4'd0, 32'd0, 32'd0, 32'd0, 1'b0, 3'd0, 2'd1);
    checkOutput("multu_hi", M_vin, 32'h40000000);

    applyStimulus(4'd0, 32'h12345678, 32'd0, 32'd0, 1'b0, 3'd5, 2'd0);
    checkOutput("mthi_busy", {31'd0, md_busy}, 32'd0);
    applyStimulus(4'd0, 32'h9ABCDEF0, 32'd0, 32'd0, 1'b0, 3'd6, 2'd1);
    checkOutput("mthi_rd", M_vin, 32'h12345678);
    applyStimulus(4'd0, 32'd0, 32'd0, 32'd0, 1'b0, 3'd0, 2'd2);
    checkOutput("mtlo_rd", M_vin, 32'h9ABCDEF0);

    applyStimulus(4'd0, 32'hFFFFFFF9, 32'd2, 32'd0, 1'b0, 3'd3, 2'd0);
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    checkOutput("mid_busy", {31'd0, md_busy}, 32'd1);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    checkOutput("abort_busy", {31'd0, md_busy}, 32'd0);
    applyStimulus(4'd0, 32'd0, 32'd0, 32'd0, 1'b0, 3'd0, 2'd1);
    checkOutput("abort_hi", M_vin, 32'd0);
    applyStimulus(4'd0, 32'd0, 32'd0, 32'd0, 1'b0, 3'd0, 2'd2);
    checkOutput("abort_lo", M_vin, 32'd0);
`else
    applyStimulus(4'd0, 32'hFFFFFFFE, 32'd3, 32'd0, 1'b0, 3'd1, 2'd0);
    checkOutput("nomd_busy", {31'd0, md_busy}, 32'd0);
    applyStimulus(4'd0, 32'h12345678, 32'd0, 32'd0, 1'b0, 3'd5, 2'd1);
    checkOutput("nomd_hi", M_vin, 32'd0);
    applyStimulus(4'd0, 32'h12345678, 32'd0, 32'd0, 1'b0, 3'd6, 2'd2);
    checkOutput("nomd_lo", M_vin, 32'd0);
    checkOutput("nomd_aluo", M_aluo, 32'h12345678);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
